// File: rtl/manchester_tx_frame.sv
// rtl/manchester_tx_frame.sv - Manchester frame transmitter: preamble + DATA_W data bits, one half-bit per clk
// Word and coding mode are latched on the valid/ready transfer; all line outputs are registered.
module manchester_tx_frame #(
  parameter int DATA_W    = 8,
  parameter int PRE_LEN   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] datain,
  input  logic              datain_valid,
  output logic              datain_ready,
  input  logic              mode,
  output logic              dataout,
  output logic              dout_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAXL = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int CW   = $clog2(MAXL + 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_adv;
  logic [CW-1:0]     bit_cnt;
  logic              mode_l;
  logic              phase;
  logic              xfer;

  function automatic logic head(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  assign shreg_adv = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);

  // frame_done marks the final half-bit, which is also the slot where the next word may be taken
  assign datain_ready = (state == IDLE) || frame_done;
  assign xfer         = datain_valid && datain_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      mode_l     <= 1'b0;
      phase      <= 1'b0;
      dataout    <= 1'b0;
      dout_en    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (xfer) begin
        shreg   <= datain;
        mode_l  <= mode;
        phase   <= 1'b0;
        bit_cnt <= '0;
        busy    <= 1'b1;
        dout_en <= 1'b1;
        if (PRE_LEN > 0) begin
          state   <= PRE;
          dataout <= 1'b1 ^ mode;
        end else begin
          state   <= DATA;
          dataout <= head(datain) ^ mode;
        end
      end else begin
        case (state)
          IDLE: begin
            dataout <= 1'b0;
            dout_en <= 1'b0;
            busy    <= 1'b0;
          end
          default: begin
            if (!phase) begin
              phase      <= 1'b1;
              dataout    <= ~dataout;
              frame_done <= (state == DATA) && (bit_cnt == DATA_LAST);
            end else begin
              phase <= 1'b0;
              if (state == PRE) begin
                if (bit_cnt == PRE_LAST) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  dataout <= head(shreg) ^ mode_l;
                end else begin
                  // next preamble bit is ~(bit_cnt+1)[0], i.e. bit_cnt[0]
                  bit_cnt <= bit_cnt + 1'b1;
                  dataout <= bit_cnt[0] ^ mode_l;
                end
              end else if (bit_cnt == DATA_LAST) begin
                state   <= IDLE;
                bit_cnt <= '0;
                shreg   <= '0;
                dataout <= 1'b0;
                dout_en <= 1'b0;
                busy    <= 1'b0;
              end else begin
                shreg   <= shreg_adv;
                bit_cnt <= bit_cnt + 1'b1;
                dataout <= head(shreg_adv) ^ mode_l;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
